// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, reads the combinational ROM, registers word+PC into an IF/ID stage.
// Latency: 1 cycle PC->out_valid, one instruction per cycle while out_ready is high.
// Backpressure: stage and PC hold while out_valid && !out_ready; a redirect flushes regardless.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] imem_a,
  input  logic [31:0] imem_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        halted,
  output logic        misaligned,
  output logic [31:0] fetch_count
);

  logic [31:0] pc;
  logic        fetch_en;
  logic        accept;
  logic [31:0] pc_next_seq;

  assign imem_a      = pc;
  assign fetch_en    = !halted && (!out_valid || out_ready);
  assign accept      = out_valid && out_ready;
  assign pc_next_seq = pc + 32'd4;

  // The handshake completes independently of redirects, so the counter has its own process.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_count <= 32'd0;
    end else if (accept) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc           <= RESET_PC;
      out_valid    <= 1'b0;
      out_instr    <= 32'd0;
      out_pc       <= 32'd0;
      out_pc_plus4 <= 32'd0;
      halted       <= 1'b0;
      misaligned   <= 1'b0;
    end else begin
      misaligned <= 1'b0;
      if (redirect_valid) begin
        pc         <= {redirect_pc[31:2], 2'b00};
        out_valid  <= 1'b0;
        halted     <= 1'b0;
        misaligned <= |redirect_pc[1:0];
      end else if (fetch_en && (imem_rd == HALT_WORD)) begin
        // Halt word is swallowed; PC stays parked on its address.
        halted    <= 1'b1;
        out_valid <= 1'b0;
      end else if (fetch_en) begin
        out_instr    <= imem_rd;
        out_pc       <= pc;
        out_pc_plus4 <= pc_next_seq;
        out_valid    <= 1'b1;
        pc           <= pc_next_seq;
      end
    end
  end

endmodule
